// File: rtl/ex_mul_pipeline.sv
// ex_mul_pipeline: five-stage unsigned multiplier, one C-bit multiplier chunk per stage
module ex_mul_pipeline #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      issue_valid_i,
    input  logic                      ex_bubble_i,
    input  logic                      stall_ex_i,
    input  logic                      op_high_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    input  logic [REGISTER_WIDTH-1:0] rd_i,
    output logic                      ex1_valid_o,
    output logic                      ex2_valid_o,
    output logic                      ex3_valid_o,
    output logic                      ex4_valid_o,
    output logic                      ex5_valid_o,
    output logic [REGISTER_WIDTH-1:0] ex1_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex2_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex3_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex4_wr_reg_o,
    output logic                      wb_valid_o,
    output logic [REGISTER_WIDTH-1:0] wb_reg_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o
);
    localparam int C  = DATA_WIDTH / 4;
    localparam int AW = 2 * DATA_WIDTH;

    logic [4:0]                valid;
    logic [REGISTER_WIDTH-1:0] rd [5];
    logic [DATA_WIDTH-1:0]     a [4];
    logic [DATA_WIDTH-1:0]     b [4];
    logic [3:0]                op_high;
    logic [AW-1:0]             acc [4];
    logic [AW-1:0]             sum [4];
    logic [DATA_WIDTH-1:0]     wb_data;

    for (genvar k = 0; k < 4; k++) begin : g_pp
        assign sum[k] = acc[k] + (({{DATA_WIDTH{1'b0}}, a[k]} * {{(AW-C){1'b0}}, b[k][k*C +: C]}) << (k*C));
    end

    // Shift every stage forward unless frozen; ex4->ex5 also selects the written-back half
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid   <= '0;
            op_high <= '0;
            wb_data <= '0;
            rd[4]   <= '0;
            for (int i = 0; i < 4; i++) begin
                rd[i]  <= '0;
                a[i]   <= '0;
                b[i]   <= '0;
                acc[i] <= '0;
            end
        end else if (!stall_ex_i) begin
            valid      <= {valid[3:0], issue_valid_i & ~ex_bubble_i};
            rd[0]      <= rd_i;
            a[0]       <= rs1_data_i;
            b[0]       <= rs2_data_i;
            op_high[0] <= op_high_i;
            acc[0]     <= '0;
            for (int i = 1; i < 4; i++) begin
                rd[i]      <= rd[i-1];
                a[i]       <= a[i-1];
                b[i]       <= b[i-1];
                op_high[i] <= op_high[i-1];
                acc[i]     <= sum[i-1];
            end
            rd[4]   <= rd[3];
            wb_data <= op_high[3] ? sum[3][AW-1:DATA_WIDTH] : sum[3][DATA_WIDTH-1:0];
        end
    end

    assign ex1_valid_o  = valid[0];
    assign ex2_valid_o  = valid[1];
    assign ex3_valid_o  = valid[2];
    assign ex4_valid_o  = valid[3];
    assign ex5_valid_o  = valid[4];
    assign ex1_wr_reg_o = rd[0];
    assign ex2_wr_reg_o = rd[1];
    assign ex3_wr_reg_o = rd[2];
    assign ex4_wr_reg_o = rd[3];
    assign wb_valid_o   = valid[4];
    assign wb_reg_o     = rd[4];
    assign wb_data_o    = wb_data;
endmodule

// File: tb/tb_ex_mul_pipeline.sv
// tb_ex_mul_pipeline: scoreboard bench for the pipelined multiplier
module tb_ex_mul_pipeline;
    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic        ex_bubble_i = 1'b0;
    logic        stall_ex_i = 1'b0;
    logic        op_high_i = 1'b0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_i = '0;
    logic        ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o, ex5_valid_o;
    logic [4:0]  ex1_wr_reg_o, ex2_wr_reg_o, ex3_wr_reg_o, ex4_wr_reg_o;
    logic        wb_valid_o;
    logic [4:0]  wb_reg_o;
    logic [31:0] wb_data_o;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    ex_mul_pipeline dut (
        .clk_i(clk), .rst_i(rst_i), .issue_valid_i(issue_valid_i), .ex_bubble_i(ex_bubble_i),
        .stall_ex_i(stall_ex_i), .op_high_i(op_high_i), .rs1_data_i(rs1_data_i),
        .rs2_data_i(rs2_data_i), .rd_i(rd_i),
        .ex1_valid_o(ex1_valid_o), .ex2_valid_o(ex2_valid_o), .ex3_valid_o(ex3_valid_o),
        .ex4_valid_o(ex4_valid_o), .ex5_valid_o(ex5_valid_o),
        .ex1_wr_reg_o(ex1_wr_reg_o), .ex2_wr_reg_o(ex2_wr_reg_o),
        .ex3_wr_reg_o(ex3_wr_reg_o), .ex4_wr_reg_o(ex4_wr_reg_o),
        .wb_valid_o(wb_valid_o), .wb_reg_o(wb_reg_o), .wb_data_o(wb_data_o)
    );

    always #5 clk = ~clk;

    wire [4:0]  vs   = {ex5_valid_o, ex4_valid_o, ex3_valid_o, ex2_valid_o, ex1_valid_o};
    wire [19:0] regs = {ex4_wr_reg_o, ex3_wr_reg_o, ex2_wr_reg_o, ex1_wr_reg_o};
    wire [37:0] wb   = {wb_valid_o, wb_reg_o, wb_data_o};

    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic hi);
        logic [63:0] p;
        p = 64'(x) * 64'(y);
        return hi ? p[63:32] : p[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one edge; it is expected back only if the edge will capture it
    task automatic send(input logic [4:0] rd, input logic [31:0] x, input logic [31:0] y, input logic hi);
        issue_valid_i = 1'b1;
        rd_i = rd;
        rs1_data_i = x;
        rs2_data_i = y;
        op_high_i = hi;
        if (!stall_ex_i && !ex_bubble_i && !rst_i) q.push_back('{rd: rd, data: model(x, y, hi)});
        tick();
        issue_valid_i = 1'b0;
    endtask

    initial begin
        logic [4:0]  sv_vs;
        logic [19:0] sv_regs;
        logic [37:0] sv_wb;
        fork
            forever begin
                @(negedge clk);
                if (wb_valid_o && !stall_ex_i && !rst_i) begin
                    if (q.size() == 0) check("wb_unexpected", {27'd0, wb_reg_o, wb_data_o}, 64'hDEAD);
                    else begin
                        exp_t e;
                        e = q.pop_front();
                        check("wb_result", {27'd0, wb_reg_o, wb_data_o}, {27'd0, e.rd, e.data});
                    end
                end
            end
        join_none

        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        check("reset_valids", 64'(vs), 0);
        check("reset_wb", 64'(wb), 0);

        send(5'd3, 32'd7, 32'd6, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t1_valid_%0d", k), 64'(vs), 64'(5'b1 << k));
            if (k < 4) check($sformatf("t1_reg_%0d", k), 64'((regs >> (5*k)) & 20'h1F), 3);
            if (k < 4) tick();
        end
        check("t1_wb", 64'(wb), {26'd0, 1'b1, 5'd3, 32'd42});
        tick();
        check("t1_empty", 64'(vs), 0);

        send(5'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        send(5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        send(5'd4, 32'h80000000, 32'd2, 1'b1);
        for (int k = 0; k < 2; k++) tick();
        check("t2_low", 64'(wb_data_o), 64'h1);
        tick();
        check("t2_high", 64'(wb_data_o), 64'hFFFFFFFE);
        tick();
        check("t2_high_msb", 64'(wb_data_o), 64'h1);
        for (int k = 0; k < 3; k++) tick();

        for (int i = 1; i <= 5; i++) send(5'(i), 32'(i), 32'(i + 1), 1'b0);
        check("t3_full", 64'(vs), 64'h1F);
        check("t3_first_wb", 64'(wb), {26'd0, 1'b1, 5'd1, 32'd2});

        sv_vs = vs;
        sv_regs = regs;
        sv_wb = wb;
        stall_ex_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(5'd9, 32'd100, 32'd100, 1'b0);
            check($sformatf("t4_hold_valid_%0d", k), 64'(vs), 64'(sv_vs));
            check($sformatf("t4_hold_regs_%0d", k), 64'(regs), 64'(sv_regs));
            check($sformatf("t4_hold_wb_%0d", k), 64'(wb), 64'(sv_wb));
        end
        stall_ex_i = 1'b0;
        tick();
        check("t4_resume", 64'(vs), 64'h1E);
        check("t4_resume_wb", 64'(wb), {26'd0, 1'b1, 5'd2, 32'd6});
        for (int k = 0; k < 4; k++) tick();
        check("t4_drained", 64'(vs), 0);

        send(5'd10, 32'd11, 32'd13, 1'b0);
        ex_bubble_i = 1'b1;
        send(5'd11, 32'd5, 32'd5, 1'b0);
        ex_bubble_i = 1'b0;
        check("t5_bubble", 64'(vs), 64'b00010);
        send(5'd12, 32'd3, 32'd9, 1'b0);
        check("t5_after", 64'(vs), 64'b00101);
        for (int k = 0; k < 6; k++) tick();
        check("t5_queue", 64'(q.size()), 0);

        send(5'd1, 32'd2, 32'd3, 1'b0);
        send(5'd2, 32'd4, 32'd5, 1'b0);
        send(5'd3, 32'd6, 32'd7, 1'b0);
        rst_i = 1'b1;
        stall_ex_i = 1'b1;
        q.delete();
        send(5'd4, 32'd8, 32'd9, 1'b0);
        rst_i = 1'b0;
        stall_ex_i = 1'b0;
        check("t6_valids", 64'(vs), 0);
        check("t6_wb_valid", 64'(wb_valid_o), 0);
        send(5'd7, 32'd1000, 32'd1000, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        check("t6_new_op", 64'(wb), {26'd0, 1'b1, 5'd7, 32'd1000000});
        tick();

        for (int n = 0; n < 400; n++) begin
            stall_ex_i = ($urandom_range(0, 4) == 0);
            ex_bubble_i = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 9) < 7) send(5'($urandom), $urandom, $urandom, 1'($urandom));
            else tick();
        end
        stall_ex_i = 1'b0;
        ex_bubble_i = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("final_queue", 64'(q.size()), 0);
        check("final_idle", 64'(vs), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
